// File: rtl/bus_initiator_pkg.sv
// Shared definitions for the bus initiator: FSM states, default widths and
// the address map implemented by the registered address decoder it talks to.
package bus_initiator_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Responder address map: these addresses return a fixed value, all others
  // echo the data that was driven on the bus.
  localparam logic [7:0] MAP0_ADDR = 8'hF0;
  localparam logic [7:0] MAP0_DATA = 8'h0F;
  localparam logic [7:0] MAP1_ADDR = 8'h0F;
  localparam logic [7:0] MAP1_DATA = 8'hF0;
  localparam logic [7:0] MAP2_ADDR = 8'hA0;
  localparam logic [7:0] MAP2_DATA = 8'hFF;

  function automatic logic [7:0] responder_map(input logic [7:0] addr,
                                               input logic [7:0] data);
    logic [7:0] result;
    case (addr)
      MAP0_ADDR: result = MAP0_DATA;
      MAP1_ADDR: result = MAP1_DATA;
      MAP2_ADDR: result = MAP2_DATA;
      default:   result = data;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/bus_initiator_if.sv
// Request/response handshakes plus the address/data bus of the initiator.
// master is the initiator's view, slave is the view of whoever surrounds it.
interface bus_initiator_if #(
  parameter int ADDR_W = bus_initiator_pkg::DEF_ADDR_W,
  parameter int DATA_W = bus_initiator_pkg::DEF_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] addr_bus;
  logic [DATA_W-1:0] data_bus_out;
  logic [DATA_W-1:0] data_bus_in;
  logic              busy;

  modport master (
    input  req_valid, req_addr, req_data, rsp_ready, data_bus_in,
    output req_ready, rsp_valid, rsp_addr, rsp_data, addr_bus, data_bus_out, busy
  );

  modport slave (
    output req_valid, req_addr, req_data, rsp_ready, data_bus_in,
    input  req_ready, rsp_valid, rsp_addr, rsp_data, addr_bus, data_bus_out, busy
  );

endinterface

// File: rtl/bus_req_fifo.sv
// Small synchronous request FIFO. The head is read straight from storage, so
// an entry written at one edge can be popped no earlier than the next edge.
module bus_req_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bus_initiator.sv
// Initiator end of the address/data bus. Requests are queued, driven onto the
// bus, held while the registered responder settles, and the returned data is
// offered as a response.
module bus_initiator #(
  parameter int DATA_W      = bus_initiator_pkg::DEF_DATA_W,
  parameter int ADDR_W      = bus_initiator_pkg::DEF_ADDR_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int RSP_LATENCY = 1
) (
  input logic             clock,
  input logic             reset,
  bus_initiator_if.master bif
);

  import bus_initiator_pkg::*;

  localparam int CNT_W   = (RSP_LATENCY < 1) ? 1 : $clog2(RSP_LATENCY + 1);
  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] CNT_LAST = RSP_LATENCY[CNT_W-1:0];

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   hold_cnt;
  logic               ready_en;
  logic               req_ready;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic               capture;
  logic               rsp_done;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic [ADDR_W-1:0]  rsp_addr_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               rsp_valid_q;

  // ready_en keeps req_ready low until the first edge after reset release.
  assign req_ready = ready_en & ~fifo_full;
  assign fifo_push = bif.req_valid & req_ready;
  assign head_addr = fifo_head[ENTRY_W-1 -: ADDR_W];
  assign head_data = fifo_head[DATA_W-1:0];

  assign bif.req_ready    = req_ready;
  assign bif.rsp_valid    = rsp_valid_q;
  assign bif.rsp_addr     = rsp_addr_q;
  assign bif.rsp_data     = rsp_data_q;
  assign bif.addr_bus     = addr_q;
  assign bif.data_bus_out = data_q;
  assign bif.busy         = (state_q != ST_IDLE) | ~fifo_empty;

  bus_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .push_data ({bif.req_addr, bif.req_data}),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // State register and the post-reset ready enable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ready_en <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_en <= 1'b1;
    end
  end

  // Next state: a completed response can launch the next request on the same edge.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (hold_cnt == CNT_LAST) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_valid_q && bif.rsp_ready) begin
          rsp_done = 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_DRIVE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus drive, hold counter and response capture; bus keeps its last value when idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      data_q      <= '0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      if (fifo_pop) begin
        addr_q     <= head_addr;
        data_q     <= head_data;
        rsp_addr_q <= head_addr;
        hold_cnt   <= '0;
      end else if (state_q == ST_DRIVE && !capture) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end
      if (capture) begin
        rsp_data_q  <= bif.data_bus_in;
        rsp_valid_q <= 1'b1;
      end else if (rsp_done) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

endmodule
